// File: rtl/updown_counter_param.sv
// Parametrised loadable up/down counter with a programmable top value,
// variable step, wrap/saturate mode and a combinational look-ahead carry.
module updown_counter_param #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s,
  input  logic              Load,
  input  logic [WIDTH-1:0]  PData,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic              sat,
  output logic [WIDTH-1:0]  cnt,
  output logic              Rc,
  output logic              tc
);

  // One guard bit so that cnt + step and limit + 1 never lose their carry.
  localparam int unsigned EW = WIDTH + 1;

  logic [EW-1:0]    cnt_x;
  logic [EW-1:0]    step_x;
  logic [EW-1:0]    limit_x;
  logic [EW-1:0]    range_x;
  logic [EW-1:0]    up_sum;
  logic [EW-1:0]    dn_diff;
  logic [EW-1:0]    up_wrap;
  logic [EW-1:0]    dn_wrap;
  logic             ovf;
  logic             udf;
  logic [WIDTH-1:0] cnt_nxt;
  logic             rc_nxt;

  // Extended-width arithmetic and boundary-crossing detection.
  always_comb begin
    cnt_x   = EW'(cnt);
    step_x  = EW'(step);
    limit_x = EW'(limit);
    range_x = limit_x + EW'(1);
    up_sum  = cnt_x + step_x;
    dn_diff = cnt_x - step_x;
    up_wrap = up_sum - range_x;
    dn_wrap = cnt_x + range_x - step_x;
    ovf     = en & s & (up_sum > limit_x);
    udf     = en & ~s & (step_x > cnt_x);
  end

  // Look-ahead carry for cascading; a pending load suppresses it.
  assign tc = ~Load & (ovf | udf);

  // Next count and crossing flag: load beats crossing beats plain count.
  always_comb begin
    cnt_nxt = cnt;
    rc_nxt  = 1'b0;
    if (Load) begin
      cnt_nxt = PData;
    end else if (ovf) begin
      cnt_nxt = sat ? limit : up_wrap[WIDTH-1:0];
      rc_nxt  = 1'b1;
    end else if (udf) begin
      cnt_nxt = sat ? '0 : dn_wrap[WIDTH-1:0];
      rc_nxt  = 1'b1;
    end else if (en) begin
      cnt_nxt = s ? up_sum[WIDTH-1:0] : dn_diff[WIDTH-1:0];
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      Rc  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      Rc  <= rc_nxt;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Testbench for updown_counter_param: directed test-plan steps plus random
// traffic, checked against an arithmetic reference model.
module tb_updown_counter_param;

  logic        clk;
  logic        rst;
  logic        en;
  logic        s;
  logic        ld;
  logic [31:0] pdata;
  logic [31:0] limit;
  logic [3:0]  step;
  logic        sat;
  logic [31:0] cnt;
  logic        rc;
  logic        tc;

  // Cascade pair
  logic        c_ld;
  logic        c_en_lo;
  logic [3:0]  c_pd_lo;
  logic [3:0]  c_pd_hi;
  logic [3:0]  lo_cnt;
  logic [3:0]  hi_cnt;
  logic        lo_rc;
  logic        hi_rc;
  logic        lo_tc;
  logic        hi_tc;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_cnt;
  logic        m_rc;

  updown_counter_param #(.WIDTH(32), .STEP_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .s(s), .Load(ld), .PData(pdata),
    .limit(limit), .step(step), .sat(sat), .cnt(cnt), .Rc(rc), .tc(tc)
  );

  updown_counter_param #(.WIDTH(4), .STEP_W(4)) u_lo (
    .clk(clk), .rst(rst), .en(c_en_lo), .s(1'b1), .Load(c_ld), .PData(c_pd_lo),
    .limit(4'hF), .step(4'd1), .sat(1'b0), .cnt(lo_cnt), .Rc(lo_rc), .tc(lo_tc)
  );

  updown_counter_param #(.WIDTH(4), .STEP_W(4)) u_hi (
    .clk(clk), .rst(rst), .en(lo_tc), .s(1'b1), .Load(c_ld), .PData(c_pd_hi),
    .limit(4'hF), .step(4'd1), .sat(1'b0), .cnt(hi_cnt), .Rc(hi_rc), .tc(hi_tc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: next count, crossing flag and look-ahead from the counting rules.
  function automatic void model(input logic [31:0] c, output logic [31:0] nc,
                                output logic nrc, output logic ntc);
    longint unsigned cv   = 64'(c);
    longint unsigned lv   = 64'(limit);
    longint unsigned sv   = 64'(step);
    longint unsigned mask = 64'hFFFF_FFFF;
    nc  = c;
    nrc = 1'b0;
    ntc = 1'b0;
    if (ld) begin
      nc = pdata;
    end else if (en) begin
      if (s) begin
        if (cv + sv > lv) begin
          ntc = 1'b1;
          nrc = 1'b1;
          nc  = sat ? limit : 32'((cv + sv - lv - 1) & mask);
        end else begin
          nc = 32'(cv + sv);
        end
      end else begin
        if (sv > cv) begin
          ntc = 1'b1;
          nrc = 1'b1;
          nc  = sat ? 32'd0 : 32'((cv + lv + 1 - sv) & mask);
        end else begin
          nc = 32'(cv - sv);
        end
      end
    end
  endfunction

  // Apply current inputs for one clock and check tc, cnt and Rc.
  task automatic cycle(input string tag);
    logic [31:0] nc;
    logic        nrc;
    logic        ntc;
    model(m_cnt, nc, nrc, ntc);
    #1;
    chk({tag, ".tc"}, 32'(tc), 32'(ntc));
    @(posedge clk);
    #1;
    m_cnt = nc;
    m_rc  = nrc;
    chk({tag, ".cnt"}, cnt, m_cnt);
    chk({tag, ".rc"}, 32'(rc), 32'(m_rc));
  endtask

  task automatic load_val(input logic [31:0] v);
    ld    = 1'b1;
    pdata = v;
    cycle("load");
    ld    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s = 1'b1; ld = 1'b0; pdata = '0;
    limit = 32'hFFFF_FFFF; step = 4'd1; sat = 1'b0;
    c_ld = 1'b0; c_en_lo = 1'b0; c_pd_lo = '0; c_pd_hi = '0;
    m_cnt = '0; m_rc = 1'b0;

    // Reset state
    #12;
    chk("reset.cnt", cnt, 32'd0);
    chk("reset.rc", 32'(rc), 32'd0);
    rst = 1'b0;

    // Asynchronous reset mid-count
    load_val(32'h1234);
    chk("rst.pre", cnt, 32'h1234);
    en = 1'b1; s = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("rst.async.cnt", cnt, 32'd0);
    chk("rst.async.rc", 32'(rc), 32'd0);
    @(posedge clk);
    #1;
    chk("rst.held.cnt", cnt, 32'd0);
    rst = 1'b0;
    m_cnt = '0; m_rc = 1'b0;
    cycle("rst.resume");
    chk("rst.resume.lit", cnt, 32'd1);

    // Classic 32-bit wrap, up and down
    en = 1'b0;
    load_val(32'hFFFF_FFFE);
    en = 1'b1; s = 1'b1;
    cycle("classic.up1");
    chk("classic.top", cnt, 32'hFFFF_FFFF);
    #1;
    chk("classic.tc", 32'(tc), 32'd1);
    cycle("classic.up2");
    chk("classic.wrap", cnt, 32'd0);
    chk("classic.wrap.rc", 32'(rc), 32'd1);
    cycle("classic.up3");
    chk("classic.rc.pulse", 32'(rc), 32'd0);
    load_val(32'd1);
    s = 1'b0;
    cycle("classic.dn1");
    cycle("classic.dn2");
    chk("classic.dnwrap", cnt, 32'hFFFF_FFFF);
    chk("classic.dnwrap.rc", 32'(rc), 32'd1);

    // Modulo counting with step 3, limit 9
    limit = 32'd9; step = 4'd3; sat = 1'b0; s = 1'b1;
    load_val(32'd0);
    for (int i = 0; i < 5; i++) cycle("mod.up");
    chk("mod.up.lit", cnt, 32'd5);
    load_val(32'd1);
    s = 1'b0;
    cycle("mod.dn1");
    chk("mod.dn.lit", cnt, 32'd8);
    cycle("mod.dn2");

    // Saturation at both ends
    limit = 32'd100; step = 4'd7; sat = 1'b1; s = 1'b1;
    load_val(32'd95);
    cycle("sat.up1");
    cycle("sat.up2");
    chk("sat.hold", cnt, 32'd100);
    chk("sat.hold.rc", 32'(rc), 32'd1);
    s = 1'b0;
    cycle("sat.back");
    chk("sat.back.lit", cnt, 32'd93);
    load_val(32'd3);
    cycle("sat.dn");
    chk("sat.zero", cnt, 32'd0);

    // Load priority at a boundary, and out-of-range load
    s = 1'b1; sat = 1'b0;
    load_val(32'd100);
    ld = 1'b1; en = 1'b1; pdata = 32'h55;
    cycle("ldpri");
    chk("ldpri.lit", cnt, 32'h55);
    ld = 1'b0;
    sat = 1'b1;
    load_val(32'd200);
    cycle("oor.up");
    chk("oor.lit", cnt, 32'd100);

    // Enable low holds, step 0 holds
    en = 1'b0;
    for (int i = 0; i < 5; i++) cycle("idle");
    en = 1'b1; step = 4'd0; s = 1'b1;
    cycle("step0.up");
    s = 1'b0;
    cycle("step0.dn");

    // Cascade of two 4-bit stages
    en = 1'b0;
    c_ld = 1'b1; c_pd_lo = 4'hF; c_pd_hi = 4'h0;
    @(posedge clk);
    #1;
    c_ld = 1'b0;
    chk("casc.pre", 32'({hi_cnt, lo_cnt}), 32'h0F);
    c_en_lo = 1'b1;
    #1;
    chk("casc.lo_tc", 32'(lo_tc), 32'd1);
    @(posedge clk);
    #1;
    c_en_lo = 1'b0;
    chk("casc.pair", 32'({hi_cnt, lo_cnt}), 32'h10);
    chk("casc.lo_rc", 32'(lo_rc), 32'd1);
    chk("casc.hi_rc", 32'(hi_rc), 32'd0);
    chk("casc.hi_tc", 32'(hi_tc), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      s     = 1'($urandom % 2);
      ld    = ($urandom_range(0, 15) == 0);
      pdata = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 60)) : $urandom;
      limit = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      step  = 4'($urandom % 16);
      sat   = 1'($urandom % 2);
      cycle("rand");
    end
    ld = 1'b0; en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
